wb_arbiter: RTL and testbench

Write-back arbiter that drives the single write port (WE3/AD3/WD3) of the integer register file. It merges two result sources: the in-order pipeline write-back stage, which has priority and no back-pressure, and a long-latency unit (divider / load miss path) buffered through a small FIFO with a valid/ready handshake. A starvation counter stalls the pipeline for one cycle so that buffered results always drain. A per-register busy vector lets the hazard unit stall readers of registers with queued writes.

---
 rtl/wb_arbiter.sv | 117 +++++++++++
 tb/tb_wb_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter for the integer register file write port: pipeline results have
// priority, long-latency results queue in a FIFO that a starvation counter forces to drain.
module wb_arbiter #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int FIFO_DEPTH    = 4,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          pipe_valid_i,
   input  logic [ADDRESS_WIDTH-1:0]      pipe_rd_i,
   input  logic [DATA_WIDTH-1:0]         pipe_data_i,
   output logic                          pipe_stall_o,
   input  logic                          mc_valid_i,
   output logic                          mc_ready_o,
   input  logic [ADDRESS_WIDTH-1:0]      mc_rd_i,
   input  logic [DATA_WIDTH-1:0]         mc_data_i,
   output logic                          WE3_o,
   output logic [ADDRESS_WIDTH-1:0]      AD3_o,
   output logic [DATA_WIDTH-1:0]         WD3_o,
   output logic [(2**ADDRESS_WIDTH)-1:0] busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);

   logic [ADDRESS_WIDTH-1:0] rd_mem_q   [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]    data_mem_q [FIFO_DEPTH];

   logic [PTR_W-1:0]         head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic [STV_W-1:0]         starve_q, starve_d;
   logic                     we_q, we_d;
   logic [ADDRESS_WIDTH-1:0] ad_q, ad_d;
   logic [DATA_WIDTH-1:0]    wd_q, wd_d;

   logic full, fifo_nempty, stall, accept, push, pipe_take, pop;
   logic [PTR_W-1:0] busy_idx;

   always_comb begin
      full        = (count_q == CNT_W'(FIFO_DEPTH));
      fifo_nempty = (count_q != '0);
      stall       = (starve_q == STV_W'(STARVE_LIMIT));
      accept      = mc_valid_i && !full;
      // x0 results are acknowledged but never stored
      push        = accept && (mc_rd_i != '0);
      pipe_take   = pipe_valid_i && (pipe_rd_i != '0) && !stall;
      pop         = fifo_nempty && !pipe_take;

      head_d  = pop  ? head_q + PTR_W'(1) : head_q;
      tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      // counter is only nonzero while entries wait, so stall always implies a pop
      starve_d = (pop || !fifo_nempty) ? '0 : starve_q + STV_W'(1);

      we_d = 1'b0;
      ad_d = ad_q;
      wd_d = wd_q;
      if (pipe_take) begin
         we_d = 1'b1;
         ad_d = pipe_rd_i;
         wd_d = pipe_data_i;
      end else if (pop) begin
         we_d = 1'b1;
         ad_d = rd_mem_q[head_q];
         wd_d = data_mem_q[head_q];
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem_q[tail_q]   <= mc_rd_i;
         data_mem_q[tail_q] <= mc_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         starve_q <= '0;
         we_q     <= 1'b0;
         ad_q     <= '0;
         wd_q     <= '0;
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         starve_q <= starve_d;
         we_q     <= we_d;
         ad_q     <= ad_d;
         wd_q     <= wd_d;
      end
   end

   always_comb begin
      busy_o   = '0;
      busy_idx = '0;
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
         busy_idx = head_q + PTR_W'(k);
         if (k < 32'(count_q)) busy_o[rd_mem_q[busy_idx]] = 1'b1;
      end
   end

   assign pipe_stall_o = stall;
   assign mc_ready_o   = rst_n && !full;
   assign WE3_o        = we_q;
   assign AD3_o        = ad_q;
   assign WD3_o        = wd_q;
   assign count_o      = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, hand-written corner sequences and a
// randomized run against a queue-based reference model.
module tb_wb_arbiter;

   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int LIMIT = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          pipe_valid;
   logic [AW-1:0] pipe_rd;
   logic [DW-1:0] pipe_data;
   logic          pipe_stall;
   logic          mc_valid;
   logic          mc_ready;
   logic [AW-1:0] mc_rd;
   logic [DW-1:0] mc_data;
   logic          we3;
   logic [AW-1:0] ad3;
   logic [DW-1:0] wd3;
   logic [31:0]   busy;
   logic [2:0]    count;

   int checks = 0;
   int errors = 0;

   wb_arbiter #(
      .ADDRESS_WIDTH(AW),
      .DATA_WIDTH   (DW),
      .FIFO_DEPTH   (DEPTH),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pipe_valid_i(pipe_valid),
      .pipe_rd_i   (pipe_rd),
      .pipe_data_i (pipe_data),
      .pipe_stall_o(pipe_stall),
      .mc_valid_i  (mc_valid),
      .mc_ready_o  (mc_ready),
      .mc_rd_i     (mc_rd),
      .mc_data_i   (mc_data),
      .WE3_o       (we3),
      .AD3_o       (ad3),
      .WD3_o       (wd3),
      .busy_o      (busy),
      .count_o     (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          pv;
      logic [AW-1:0] prd;
      logic [DW-1:0] pdata;
      logic          mv;
      logic [AW-1:0] mrd;
      logic [DW-1:0] mdata;
      logic          we;
      logic [AW-1:0] ad;
      logic [DW-1:0] wd;
      logic [2:0]    cnt;
      logic [31:0]   bsy;
      logic          stall;
      logic          rdy;
   } vec_t;

   typedef struct {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } ent_t;

   ent_t          q[$];
   int            m_starve;
   logic          m_we;
   logic [AW-1:0] m_ad;
   logic [DW-1:0] m_wd;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic pv, input logic [AW-1:0] prd, input logic [DW-1:0] pd,
                        input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md);
      pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
      mc_valid = mv; mc_rd = mrd; mc_data = md;
   endtask

   task automatic model_reset();
      q.delete();
      m_starve = 0;
      m_we = 1'b0;
      m_ad = '0;
      m_wd = '0;
   endtask

   // One clock edge of the arbiter's rules, applied to the current inputs
   task automatic model_step();
      ent_t e;
      bit   stall_m = (m_starve == LIMIT);
      int   sz = q.size();
      bit   acc = mc_valid && (sz < DEPTH);
      if (pipe_valid && pipe_rd != 0 && !stall_m) begin
         m_we = 1'b1; m_ad = pipe_rd; m_wd = pipe_data;
         if (sz > 0) m_starve++;
      end else if (sz > 0) begin
         e = q.pop_front();
         m_we = 1'b1; m_ad = e.rd; m_wd = e.data;
         m_starve = 0;
      end else begin
         m_we = 1'b0;
      end
      if (acc && mc_rd != 0) begin
         e.rd = mc_rd; e.data = mc_data;
         q.push_back(e);
      end
      if (q.size() == 0) m_starve = 0;
   endtask

   function automatic logic [31:0] model_busy();
      logic [31:0] b = '0;
      foreach (q[i]) b[q[i].rd] = 1'b1;
      return b;
   endfunction

   always @(negedge clk) begin
      if (rst_n && pipe_stall && pipe_valid) begin
         errors++;
         $display("FAIL protocol at %0t: pipe_valid=1 while pipe_stall=1", $time);
      end
   end

   vec_t vec[11];

   initial begin
      vec[0]  = '{0, 0, 0,      1, 5, 32'hDEADBEEF, 0, 0, 0,            1, 32'h20,  0, 1};
      vec[1]  = '{0, 0, 0,      0, 0, 0,            1, 5, 32'hDEADBEEF, 0, 32'h0,   0, 1};
      vec[2]  = '{0, 0, 0,      1, 7, 32'h77,       0, 5, 32'hDEADBEEF, 1, 32'h80,  0, 1};
      vec[3]  = '{1, 3, 32'h300, 0, 0, 0,           1, 3, 32'h300,      1, 32'h80,  0, 1};
      vec[4]  = '{1, 4, 32'h400, 0, 0, 0,           1, 4, 32'h400,      1, 32'h80,  0, 1};
      vec[5]  = '{1, 5, 32'h500, 0, 0, 0,           1, 5, 32'h500,      1, 32'h80,  0, 1};
      vec[6]  = '{1, 6, 32'h600, 0, 0, 0,           1, 6, 32'h600,      1, 32'h80,  1, 1};
      vec[7]  = '{0, 0, 0,      0, 0, 0,            1, 7, 32'h77,       0, 32'h0,   0, 1};
      vec[8]  = '{1, 0, 32'h999, 1, 0, 32'h111,     0, 7, 32'h77,       0, 32'h0,   0, 1};
      vec[9]  = '{0, 0, 0,      1, 9, 32'h90,       0, 7, 32'h77,       1, 32'h200, 0, 1};
      vec[10] = '{1, 0, 32'h999, 0, 0, 0,           1, 9, 32'h90,       0, 32'h0,   0, 1};

      // reset held with an offer pending
      rst_n = 1'b0;
      drive(0, 0, 0, 1, 3, 32'h33);
      tick();
      chk("rst_ready", mc_ready, 0);
      chk("rst_we",    we3,      0);
      chk("rst_busy",  busy,     0);
      chk("rst_count", count,    0);
      chk("rst_stall", pipe_stall, 0);
      rst_n = 1'b1;
      #1;
      chk("rel_ready", mc_ready, 1);
      mc_valid = 1'b0;

      for (int i = 0; i < 11; i++) begin
         drive(vec[i].pv, vec[i].prd, vec[i].pdata, vec[i].mv, vec[i].mrd, vec[i].mdata);
         tick();
         chk($sformatf("v%0d_we", i),    we3,        vec[i].we);
         chk($sformatf("v%0d_ad", i),    ad3,        vec[i].ad);
         chk($sformatf("v%0d_wd", i),    wd3,        vec[i].wd);
         chk($sformatf("v%0d_cnt", i),   count,      vec[i].cnt);
         chk($sformatf("v%0d_busy", i),  busy,       vec[i].bsy);
         chk($sformatf("v%0d_stall", i), pipe_stall, vec[i].stall);
         chk($sformatf("v%0d_rdy", i),   mc_ready,   vec[i].rdy);
      end

      // fill the FIFO while the pipeline owns the port
      for (int k = 1; k <= 4; k++) begin
         drive(1, 10, 32'hA0 + k, 1, AW'(k), 32'h1000 + k);
         tick();
      end
      chk("full_cnt",   count,      4);
      chk("full_rdy",   mc_ready,   0);
      chk("full_busy",  busy,       32'h1E);
      chk("full_stall", pipe_stall, 0);
      drive(1, 10, 32'hA5, 1, 5, 32'h1005);
      tick();
      chk("held_cnt",   count,      4);
      chk("held_stall", pipe_stall, 1);
      chk("held_wd",    wd3,        32'hA5);
      drive(0, 0, 0, 1, 5, 32'h1005);
      tick();
      chk("drain_we",   we3,        1);
      chk("drain_ad",   ad3,        1);
      chk("drain_wd",   wd3,        32'h1001);
      chk("drain_cnt",  count,      3);
      chk("drain_rdy",  mc_ready,   1);
      chk("drain_busy", busy,       32'h1C);
      tick();
      chk("acc5_ad",    ad3,        2);
      chk("acc5_cnt",   count,      3);
      chk("acc5_busy",  busy,       32'h38);
      mc_valid = 1'b0;

      // asynchronous reset between edges with three queued entries
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset_we",    we3,      0);
      chk("areset_ad",    ad3,      0);
      chk("areset_wd",    wd3,      0);
      chk("areset_cnt",   count,    0);
      chk("areset_busy",  busy,     0);
      chk("areset_rdy",   mc_ready, 0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("arel_rdy", mc_ready, 1);

      model_reset();
      for (int n = 0; n < 600; n++) begin
         pipe_valid = (m_starve != LIMIT) && ($urandom_range(3) != 0);
         pipe_rd    = AW'($urandom_range(31));
         pipe_data  = $urandom;
         mc_valid   = ($urandom_range(2) != 0);
         mc_rd      = AW'($urandom_range(31));
         mc_data    = $urandom;
         model_step();
         tick();
         chk("rnd_we",    we3,        m_we);
         if (m_we) begin
            chk("rnd_ad", ad3, m_ad);
            chk("rnd_wd", wd3, m_wd);
         end
         chk("rnd_cnt",   count,      q.size());
         chk("rnd_busy",  busy,       model_busy());
         chk("rnd_stall", pipe_stall, (m_starve == LIMIT));
         chk("rnd_rdy",   mc_ready,   (q.size() < DEPTH));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
